ram_port_arb: RTL and testbench

RAM_PORT_ARB -- requirements
Module: ram_port_arb

---
 rtl/ram_port_arb_pkg.sv | 28 ++
 rtl/ram_port_arb_rr_pick.sv | 28 ++
 rtl/ram_port_arb.sv | 122 ++++++++++++
 tb/tb_ram_port_arb.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_port_arb_pkg.sv
// Shared SoC memory package: port-index and burst-hold types used by the
// RAM port arbiter and its round-robin picker.
package ram_port_arb_pkg;

    localparam int PORTS_MIN   = 2;
    localparam int PORTS_MAX   = 4;
    localparam int BURST_MIN   = 1;
    localparam int BURST_LIMIT = 16;

    localparam int PORT_IDX_W = $clog2(PORTS_MAX);
    localparam int HOLD_W     = $clog2(BURST_LIMIT);

    typedef logic [PORT_IDX_W-1:0] port_idx_t;
    typedef logic [HOLD_W-1:0]     hold_cnt_t;

    // Registered arbitration state, kept in one struct so it is easy to observe.
    typedef struct packed {
        port_idx_t last_owner;
        hold_cnt_t hold_cnt;
        logic      granted;
    } arb_state_t;

    function automatic port_idx_t next_port(input port_idx_t p, input int n);
        if (int'(p) >= n - 1) return '0;
        return p + port_idx_t'(1);
    endfunction

endpackage

// File: rtl/ram_port_arb_rr_pick.sv
// Combinational round-robin picker: one-hot grant of the first requester
// found at or after the start index, wrapping to the lowest index.
module rr_pick
    import ram_port_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2
) (
    input  logic [NUM_PORTS-1:0] req,
    input  port_idx_t            start,
    output logic [NUM_PORTS-1:0] gnt
);

    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (!found && req[k] && (k == (int'(start) + i) % NUM_PORTS)) begin
                    gnt[k] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ram_port_arb.sv
// Round-robin arbiter sharing one single-port RAM among NUM_PORTS requesters,
// with bounded burst hold and one-cycle read-data return.
module ram_port_arb
    import ram_port_arb_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 40,
    parameter int DATA_WIDTH = 128,
    parameter int BURST_MAX  = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_PORTS-1:0]              p_req_i,
    output logic [NUM_PORTS-1:0]              p_gnt_o,
    input  logic [NUM_PORTS-1:0]              p_we_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   p_addr_i,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] p_be_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   p_wdata_i,
    output logic [NUM_PORTS-1:0]              p_rvalid_o,
    output logic [DATA_WIDTH-1:0]             p_rdata_o,
    output logic                              ram_req_o,
    output logic                              ram_we_o,
    output logic [ADDR_WIDTH-1:0]             ram_addr_o,
    output logic [DATA_WIDTH/8-1:0]           ram_be_o,
    output logic [DATA_WIDTH-1:0]             ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]             ram_rdata_i
);

    localparam int        BE_W     = DATA_WIDTH / 8;
    localparam hold_cnt_t HOLD_MAX = hold_cnt_t'(BURST_MAX - 1);

    arb_state_t           state;
    logic [NUM_PORTS-1:0] rvalid;
    logic [NUM_PORTS-1:0] rr_gnt;
    logic [NUM_PORTS-1:0] gnt;
    logic                 owner_req;
    logic                 hold;
    port_idx_t            start;
    port_idx_t            gnt_idx;

    always_comb begin
        owner_req = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (port_idx_t'(k) == state.last_owner) owner_req = p_req_i[k];
        end
    end

    // The owner keeps the RAM only while its burst budget lasts; at saturation
    // round-robin still lands back on it when nobody else is asking.
    assign hold  = state.granted && owner_req && (state.hold_cnt < HOLD_MAX);
    assign start = next_port(state.last_owner, NUM_PORTS);

    rr_pick #(
        .NUM_PORTS(NUM_PORTS)
    ) u_rr_pick (
        .req  (p_req_i),
        .start(start),
        .gnt  (rr_gnt)
    );

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        if (!reset) begin
            if (hold) begin
                for (int k = 0; k < NUM_PORTS; k++) begin
                    if (port_idx_t'(k) == state.last_owner) gnt[k] = 1'b1;
                end
            end else begin
                gnt = rr_gnt;
            end
        end
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (gnt[k]) gnt_idx = port_idx_t'(k);
        end
    end

    always_comb begin
        ram_we_o    = 1'b0;
        ram_addr_o  = '0;
        ram_be_o    = '0;
        ram_wdata_o = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (gnt[k]) begin
                ram_we_o    = p_we_i[k];
                ram_addr_o  = p_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                ram_be_o    = p_be_i[k*BE_W +: BE_W];
                ram_wdata_o = p_wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign ram_req_o  = |gnt;
    assign p_gnt_o    = gnt;
    assign p_rvalid_o = rvalid;
    assign p_rdata_o  = ram_rdata_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state.last_owner <= port_idx_t'(NUM_PORTS - 1);
            state.hold_cnt   <= '0;
            state.granted    <= 1'b0;
            rvalid           <= '0;
        end else begin
            rvalid <= gnt & ~p_we_i;
            if (|gnt) begin
                state.granted    <= 1'b1;
                state.last_owner <= gnt_idx;
                if (state.granted && (gnt_idx == state.last_owner)) begin
                    state.hold_cnt <= (state.hold_cnt == HOLD_MAX) ? HOLD_MAX
                                                                   : state.hold_cnt + hold_cnt_t'(1);
                end else begin
                    state.hold_cnt <= '0;
                end
            end else begin
                state.granted  <= 1'b0;
                state.hold_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ram_port_arb.sv
// Bench for ram_port_arb: three configurations (2 ports/burst 4, 2 ports/burst 1,
// 3 ports/burst 2) against a run-length round-robin reference model and a RAM model.
module tb_ram_port_arb;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // 2-port stimulus shared by dut_a and dut_b
    logic [1:0]   req2 = '0, we2 = '0;
    logic [79:0]  addr2 = '0;
    logic [31:0]  be2 = '0;
    logic [255:0] wdata2 = '0;
    // 3-port stimulus for dut_c
    logic [2:0]   req3 = '0, we3 = '0;
    logic [119:0] addr3 = '0;
    logic [47:0]  be3 = '0;
    logic [383:0] wdata3 = '0;

    logic [1:0]   gnt_a, rvalid_a, gnt_b, rvalid_b;
    logic [2:0]   gnt_c, rvalid_c;
    logic [127:0] rdata_a, rdata_b, rdata_c, ram_rdata, zero_data;
    logic         ram_req_a, ram_we_a, ram_req_b, ram_we_b, ram_req_c, ram_we_c;
    logic [39:0]  ram_addr_a, ram_addr_b, ram_addr_c;
    logic [15:0]  ram_be_a, ram_be_b, ram_be_c;
    logic [127:0] ram_wdata_a, ram_wdata_b, ram_wdata_c;

    assign zero_data = '0;

    ram_port_arb #(.NUM_PORTS(2), .ADDR_WIDTH(40), .DATA_WIDTH(128), .BURST_MAX(4)) dut_a (
        .clk(clk), .reset(reset), .p_req_i(req2), .p_gnt_o(gnt_a), .p_we_i(we2),
        .p_addr_i(addr2), .p_be_i(be2), .p_wdata_i(wdata2), .p_rvalid_o(rvalid_a),
        .p_rdata_o(rdata_a), .ram_req_o(ram_req_a), .ram_we_o(ram_we_a),
        .ram_addr_o(ram_addr_a), .ram_be_o(ram_be_a), .ram_wdata_o(ram_wdata_a),
        .ram_rdata_i(ram_rdata));

    ram_port_arb #(.NUM_PORTS(2), .ADDR_WIDTH(40), .DATA_WIDTH(128), .BURST_MAX(1)) dut_b (
        .clk(clk), .reset(reset), .p_req_i(req2), .p_gnt_o(gnt_b), .p_we_i(we2),
        .p_addr_i(addr2), .p_be_i(be2), .p_wdata_i(wdata2), .p_rvalid_o(rvalid_b),
        .p_rdata_o(rdata_b), .ram_req_o(ram_req_b), .ram_we_o(ram_we_b),
        .ram_addr_o(ram_addr_b), .ram_be_o(ram_be_b), .ram_wdata_o(ram_wdata_b),
        .ram_rdata_i(zero_data));

    ram_port_arb #(.NUM_PORTS(3), .ADDR_WIDTH(40), .DATA_WIDTH(128), .BURST_MAX(2)) dut_c (
        .clk(clk), .reset(reset), .p_req_i(req3), .p_gnt_o(gnt_c), .p_we_i(we3),
        .p_addr_i(addr3), .p_be_i(be3), .p_wdata_i(wdata3), .p_rvalid_o(rvalid_c),
        .p_rdata_o(rdata_c), .ram_req_o(ram_req_c), .ram_we_o(ram_we_c),
        .ram_addr_o(ram_addr_c), .ram_be_o(ram_be_c), .ram_wdata_o(ram_wdata_c),
        .ram_rdata_i(zero_data));

    // RAM behind dut_a: one access per cycle, read data one cycle later
    logic [127:0] ram_mem [16];
    initial begin
        for (int i = 0; i < 16; i++) ram_mem[i] = '0;
        ram_rdata = '0;
    end
    always @(posedge clk) begin
        if (ram_req_a) begin
            if (ram_we_a) begin
                for (int b = 0; b < 16; b++)
                    if (ram_be_a[b]) ram_mem[ram_addr_a[7:4]][b*8 +: 8] <= ram_wdata_a[b*8 +: 8];
            end else begin
                ram_rdata <= ram_mem[ram_addr_a[7:4]];
            end
        end
    end

    int n_checks = 0;
    int n_pass = 0;

    // Reference model: owner keeps the RAM while its current run is shorter
    // than the burst limit, otherwise first requester after the owner wins.
    int           m_last [3];
    int           m_run [3];
    bit           m_prev [3];
    int           m_n [3];
    int           m_burst [3];
    logic [3:0]   exp_rv [3];
    logic [127:0] model_mem [16];
    logic [127:0] exp_q [$];

    function automatic int model_pick(input int d, input logic [3:0] req);
        if (m_prev[d] && req[m_last[d]] && m_run[d] < m_burst[d]) return m_last[d];
        for (int i = 1; i <= m_n[d]; i++) begin
            if (req[(m_last[d] + i) % m_n[d]]) return (m_last[d] + i) % m_n[d];
        end
        return -1;
    endfunction

    task automatic model_update(input int d, input int g);
        if (g >= 0) begin
            m_run[d]  = (m_prev[d] && g == m_last[d]) ? m_run[d] + 1 : 1;
            m_last[d] = g;
            m_prev[d] = 1'b1;
        end else begin
            m_prev[d] = 1'b0;
            m_run[d]  = 0;
        end
    endtask

    function automatic logic [3:0] onehot(input int g);
        return (g < 0) ? 4'b0 : (4'b1 << g);
    endfunction

    task automatic model_reset();
        m_n     = '{2, 2, 3};
        m_burst = '{4, 1, 2};
        for (int d = 0; d < 3; d++) begin
            m_last[d] = m_n[d] - 1;
            m_run[d]  = 0;
            m_prev[d] = 1'b0;
            exp_rv[d] = '0;
        end
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        req2 = '0; we2 = '0; req3 = '0; we3 = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        req2 = 2'b11; we2 = '0; req3 = 3'b111; we3 = '0;
        #2;
        n_checks++;
        if (gnt_a !== 2'b00 || ram_req_a !== 1'b0) $display("FAIL reset_gnt_a: gnt=%b ram_req=%b expected 00/0", gnt_a, ram_req_a);
        else n_pass++;
        n_checks++;
        if (gnt_c !== 3'b000 || rvalid_c !== 3'b000) $display("FAIL reset_gnt_c: gnt=%b rvalid=%b expected 000/000", gnt_c, rvalid_c);
        else n_pass++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        n_checks++;
        if (dut_a.state.last_owner !== 2'd1 || dut_a.state.hold_cnt !== 4'd0 || dut_a.state.granted !== 1'b0)
            $display("FAIL reset_state_a: last_owner=%0d hold=%0d granted=%b expected 1/0/0",
                     dut_a.state.last_owner, dut_a.state.hold_cnt, dut_a.state.granted);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (gnt_a !== 2'b01 || rvalid_a !== 2'b00) $display("FAIL reset_first_a: gnt=%b rvalid=%b expected 01/00", gnt_a, rvalid_a);
        else n_pass++;
        n_checks++;
        if (gnt_c !== 3'b001) $display("FAIL reset_first_c: gnt=%b expected 001", gnt_c);
        else n_pass++;
        @(posedge clk);
        #1;
        req2 = '0; req3 = '0;
    endtask

    task automatic test_random();
        logic [3:0] e;
        int ea, eb, ec, idx;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            req2 = {2'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3) != 0)} & 2'b11;
            req2 = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)};
            we2  = 2'($urandom_range(0, 3));
            req3 = 3'($urandom_range(0, 7));
            we3  = 3'($urandom_range(0, 7));
            for (int p = 0; p < 2; p++) addr2[p*40 +: 40] = 40'($urandom_range(0, 15)) << 4;
            be2    = $urandom;
            wdata2 = {8{$urandom}};
            @(negedge clk);
            ea = model_pick(0, {2'b00, req2});
            eb = model_pick(1, {2'b00, req2});
            ec = model_pick(2, {1'b0, req3});
            e = onehot(ea);
            n_checks++;
            if (gnt_a !== e[1:0]) $display("FAIL rand_gnt_a cyc %0d: got %b expected %b", cyc, gnt_a, e[1:0]);
            else n_pass++;
            e = onehot(eb);
            n_checks++;
            if (gnt_b !== e[1:0]) $display("FAIL rand_gnt_b cyc %0d: got %b expected %b", cyc, gnt_b, e[1:0]);
            else n_pass++;
            e = onehot(ec);
            n_checks++;
            if (gnt_c !== e[2:0]) $display("FAIL rand_gnt_c cyc %0d: got %b expected %b", cyc, gnt_c, e[2:0]);
            else n_pass++;
            e = exp_rv[0];
            n_checks++;
            if (rvalid_a !== e[1:0]) $display("FAIL rand_rvalid_a cyc %0d: got %b expected %b", cyc, rvalid_a, e[1:0]);
            else n_pass++;
            e = exp_rv[1];
            n_checks++;
            if (rvalid_b !== e[1:0]) $display("FAIL rand_rvalid_b cyc %0d: got %b expected %b", cyc, rvalid_b, e[1:0]);
            else n_pass++;
            e = exp_rv[2];
            n_checks++;
            if (rvalid_c !== e[2:0]) $display("FAIL rand_rvalid_c cyc %0d: got %b expected %b", cyc, rvalid_c, e[2:0]);
            else n_pass++;
            if (exp_rv[0] != 0) begin
                n_checks++;
                if (exp_q.size() == 0) $display("FAIL rand_rdata cyc %0d: no expected read data queued", cyc);
                else if (rdata_a !== exp_q[0]) $display("FAIL rand_rdata cyc %0d: got %h expected %h", cyc, rdata_a, exp_q[0]);
                else n_pass++;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            n_checks++;
            if (ram_req_a !== (ea >= 0)) $display("FAIL rand_ram_req cyc %0d: got %b expected %b", cyc, ram_req_a, ea >= 0);
            else n_pass++;
            if (ea >= 0) begin
                n_checks++;
                if (ram_addr_a !== addr2[ea*40 +: 40] || ram_we_a !== we2[ea] || ram_be_a !== be2[ea*16 +: 16])
                    $display("FAIL rand_ram_mux cyc %0d: addr=%h we=%b be=%h expected %h/%b/%h", cyc,
                             ram_addr_a, ram_we_a, ram_be_a, addr2[ea*40 +: 40], we2[ea], be2[ea*16 +: 16]);
                else n_pass++;
                idx = int'(addr2[ea*40+4 +: 4]);
                if (we2[ea]) begin
                    for (int b = 0; b < 16; b++)
                        if (be2[ea*16+b]) model_mem[idx][b*8 +: 8] = wdata2[ea*128 + b*8 +: 8];
                end else begin
                    exp_q.push_back(model_mem[idx]);
                end
            end
            exp_rv[0] = (ea >= 0 && !we2[ea]) ? onehot(ea) : 4'b0;
            exp_rv[1] = (eb >= 0 && !we2[eb]) ? onehot(eb) : 4'b0;
            exp_rv[2] = (ec >= 0 && !we3[ec]) ? onehot(ec) : 4'b0;
            model_update(0, ea);
            model_update(1, eb);
            model_update(2, ec);
            @(posedge clk);
            #1;
        end
        req2 = '0; we2 = '0; req3 = '0; we3 = '0;
    endtask

    task automatic test_alternate();
        logic [1:0] exp_g, prev_g;
        do_reset();
        req2 = 2'b11; we2 = 2'b00;
        prev_g = 2'b00;
        for (int i = 0; i < 8; i++) begin
            exp_g = (i % 2 == 1) ? 2'b10 : 2'b01;
            @(negedge clk);
            n_checks++;
            if (gnt_b !== exp_g) $display("FAIL alt_gnt cyc %0d: got %b expected %b", i, gnt_b, exp_g);
            else n_pass++;
            n_checks++;
            if (rvalid_b !== prev_g) $display("FAIL alt_rvalid cyc %0d: got %b expected %b", i, rvalid_b, prev_g);
            else n_pass++;
            prev_g = exp_g;
            @(posedge clk);
            #1;
        end
        req2 = '0;
    endtask

    task automatic test_burst();
        logic [1:0] exp_g;
        do_reset();
        req2 = 2'b11; we2 = 2'b11;
        for (int i = 0; i < 16; i++) begin
            exp_g = ((i / 4) % 2 == 1) ? 2'b10 : 2'b01;
            @(negedge clk);
            n_checks++;
            if (gnt_a !== exp_g) $display("FAIL burst_gnt cyc %0d: got %b expected %b", i, gnt_a, exp_g);
            else n_pass++;
            @(posedge clk);
            #1;
        end
        req2 = '0; we2 = '0;
    endtask

    task automatic test_single();
        do_reset();
        req2 = 2'b10; we2 = 2'b00;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (gnt_a !== 2'b10) $display("FAIL single_gnt cyc %0d: got %b expected 10", i, gnt_a);
            else n_pass++;
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (dut_a.state.hold_cnt !== 4'd3) $display("FAIL single_hold: got %0d expected 3", dut_a.state.hold_cnt);
        else n_pass++;
        req2 = '0;
    endtask

    task automatic test_write_read();
        logic [127:0] pat;
        pat = {16{8'hA5}};
        do_reset();
        req2 = 2'b01; we2 = 2'b01;
        addr2[39:0] = 40'h1000; be2[15:0] = 16'hFFFF; wdata2[127:0] = pat;
        @(negedge clk);
        n_checks++;
        if (gnt_a !== 2'b01 || ram_we_a !== 1'b1 || ram_addr_a !== 40'h1000 || ram_wdata_a !== pat || ram_be_a !== 16'hFFFF)
            $display("FAIL wr_issue: gnt=%b we=%b addr=%h be=%h expected 01/1/1000/ffff", gnt_a, ram_we_a, ram_addr_a, ram_be_a);
        else n_pass++;
        @(posedge clk);
        #1;
        we2 = 2'b00;
        @(negedge clk);
        n_checks++;
        if (rvalid_a !== 2'b00 || gnt_a !== 2'b01 || ram_we_a !== 1'b0)
            $display("FAIL wr_no_rvalid: rvalid=%b gnt=%b we=%b expected 00/01/0", rvalid_a, gnt_a, ram_we_a);
        else n_pass++;
        @(posedge clk);
        #1;
        req2 = 2'b00;
        @(negedge clk);
        n_checks++;
        if (rvalid_a !== 2'b01 || rdata_a !== pat) $display("FAIL rd_data: rvalid=%b rdata=%h expected 01/%h", rvalid_a, rdata_a, pat);
        else n_pass++;
        @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if (rvalid_a !== 2'b00) $display("FAIL rd_single_pulse: rvalid=%b expected 00", rvalid_a);
        else n_pass++;
    endtask

    task automatic test_reset_pending();
        do_reset();
        req2 = 2'b10; we2 = 2'b00;
        @(negedge clk);
        n_checks++;
        if (gnt_a !== 2'b10) $display("FAIL pend_gnt: got %b expected 10", gnt_a);
        else n_pass++;
        @(posedge clk);
        #1;
        reset = 1'b1;
        req2 = 2'b00;
        #1;
        n_checks++;
        if (rvalid_a !== 2'b00) $display("FAIL pend_rvalid_async: got %b expected 00", rvalid_a);
        else n_pass++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        req2 = 2'b11;
        @(negedge clk);
        n_checks++;
        if (rvalid_a !== 2'b00 || gnt_a !== 2'b01) $display("FAIL pend_after: rvalid=%b gnt=%b expected 00/01", rvalid_a, gnt_a);
        else n_pass++;
        @(posedge clk);
        #1;
        req2 = '0;
    endtask

    task automatic test_wrap();
        logic [2:0] exp_g [4];
        logic [2:0] req_seq [4];
        exp_g   = '{3'b100, 3'b001, 3'b001, 3'b010};
        req_seq = '{3'b100, 3'b011, 3'b011, 3'b011};
        do_reset();
        we3 = 3'b000;
        for (int i = 0; i < 4; i++) begin
            req3 = req_seq[i];
            @(negedge clk);
            n_checks++;
            if (gnt_c !== exp_g[i]) $display("FAIL wrap_gnt step %0d: got %b expected %b", i, gnt_c, exp_g[i]);
            else n_pass++;
            @(posedge clk);
            #1;
        end
        req3 = '0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) model_mem[i] = '0;
        model_reset();
        test_reset();
        test_random();
        test_alternate();
        test_burst();
        test_single();
        test_write_read();
        test_reset_pending();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
